// File: rtl/mem_burst_scheduler.sv
// Round-robin burst scheduler sharing one cell-RAM port between 2*NUM_CH
// tracking-FIFO slots: slots 0..NUM_CH-1 are write (FIFO->RAM) channels, slots
// NUM_CH..2*NUM_CH-1 are read (RAM->FIFO) channels. It only issues commands to
// the burst engine; no data passes through here.
// Optional build macro MEM_BURST_SCHED_PARTIAL_FLUSH_EN adds a partial-burst
// flush after FLUSH_TIMEOUT idle cycles.
module mem_burst_scheduler #(
  parameter int unsigned NUM_CH        = 8,
  parameter int unsigned BURST         = 32,
  parameter int unsigned LVL_W         = 11,
  parameter int unsigned CNT_W         = 32,
  parameter int unsigned FLUSH_TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [2*NUM_CH-1:0]       chan_enable,
  input  logic [NUM_CH*LVL_W-1:0]   wr_fifo_level,
  input  logic [NUM_CH*LVL_W-1:0]   rd_fifo_space,
  input  logic [NUM_CH*CNT_W-1:0]   ram_level,
  output logic                      burst_valid,
  output logic [3:0]                burst_slot,
  output logic [LVL_W-1:0]          burst_len,
  input  logic                      burst_ready,
  input  logic                      burst_done,
  output logic                      busy,
  output logic [15:0]               grant_count
);

  localparam int unsigned NSLOT = 2 * NUM_CH;

  // The 4-bit slot field and 16-bit idle counter fix the legal configuration.
  if (NUM_CH != 8 || FLUSH_TIMEOUT > 65535) begin : g_bad_cfg
    $error("mem_burst_scheduler: NUM_CH must be 8 and FLUSH_TIMEOUT <= 65535");
  end

  typedef enum logic [1:0] {StIdle, StScan, StIssue, StWaitDone} state_e;

  state_e             state_q, state_d;
  logic [NSLOT-1:0]   elig, elig_q, elig_d;
  logic [3:0]         last_slot_q, last_slot_d;
  logic               valid_d, busy_d;
  logic [3:0]         slot_d;
  logic [LVL_W-1:0]   len_d;
  logic [15:0]        count_d;
  logic               pick_found;
  logic [3:0]         pick_slot;
  logic [3:0]         scan_idx;

  // Full-burst eligibility of every slot from the live FIFO/RAM levels.
  always_comb begin
    elig = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      elig[i] = chan_enable[i] && (wr_fifo_level[i*LVL_W +: LVL_W] >= LVL_W'(BURST));
      elig[NUM_CH+i] = chan_enable[NUM_CH+i]
                       && (rd_fifo_space[i*LVL_W +: LVL_W] >= LVL_W'(BURST))
                       && (ram_level[i*CNT_W +: CNT_W] >= CNT_W'(BURST));
    end
  end

  // Round-robin search of the snapshot starting just after the last granted
  // slot; the 16th probe wraps back onto last_slot itself.
  always_comb begin
    pick_found = 1'b0;
    pick_slot  = last_slot_q;
    scan_idx   = last_slot_q;
    for (int k = 1; k <= int'(NSLOT); k++) begin
      scan_idx = last_slot_q + 4'(k);
      if (!pick_found && elig_q[scan_idx]) begin
        pick_found = 1'b1;
        pick_slot  = scan_idx;
      end
    end
  end

`ifdef MEM_BURST_SCHED_PARTIAL_FLUSH_EN
  logic [15:0]                  idle_cnt_q, idle_cnt_d;
  logic                         flush_q, flush_d;
  logic [NSLOT-1:0]             part_vec;
  logic [NSLOT-1:0][LVL_W-1:0]  part_len, part_len_q, part_len_d;
  logic [CNT_W-1:0]             rd_space_ext, rd_min;

  // Partial amounts per slot, already capped at one full burst.
  always_comb begin
    part_vec     = '0;
    part_len     = '0;
    rd_space_ext = '0;
    rd_min       = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (wr_fifo_level[i*LVL_W +: LVL_W] > LVL_W'(BURST)) begin
        part_len[i] = LVL_W'(BURST);
      end else begin
        part_len[i] = wr_fifo_level[i*LVL_W +: LVL_W];
      end
      rd_space_ext = CNT_W'(rd_fifo_space[i*LVL_W +: LVL_W]);
      rd_min = (rd_space_ext < ram_level[i*CNT_W +: CNT_W]) ? rd_space_ext
                                                           : ram_level[i*CNT_W +: CNT_W];
      if (rd_min > CNT_W'(BURST)) begin
        part_len[NUM_CH+i] = LVL_W'(BURST);
      end else begin
        part_len[NUM_CH+i] = LVL_W'(rd_min);
      end
    end
    for (int s = 0; s < int'(NSLOT); s++) begin
      part_vec[s] = chan_enable[s] && (part_len[s] != '0);
    end
  end
`endif

  // Next-state and registered-output logic; everything holds by default.
  always_comb begin
    state_d     = state_q;
    elig_d      = elig_q;
    last_slot_d = last_slot_q;
    valid_d     = burst_valid;
    slot_d      = burst_slot;
    len_d       = burst_len;
    busy_d      = busy;
    count_d     = grant_count;
`ifdef MEM_BURST_SCHED_PARTIAL_FLUSH_EN
    flush_d     = flush_q;
    part_len_d  = part_len_q;
    idle_cnt_d  = idle_cnt_q;
    if ((state_q == StIdle || state_q == StScan) && elig_q == '0
        && idle_cnt_q < 16'(FLUSH_TIMEOUT)) begin
      idle_cnt_d = idle_cnt_q + 16'd1;
    end
`endif
    case (state_q)
      StIdle: begin
`ifdef MEM_BURST_SCHED_PARTIAL_FLUSH_EN
        if (idle_cnt_q >= 16'(FLUSH_TIMEOUT)) begin
          elig_d     = part_vec;
          part_len_d = part_len;
          flush_d    = 1'b1;
        end else begin
          elig_d  = elig;
          flush_d = 1'b0;
        end
`else
        elig_d = elig;
`endif
        state_d = StScan;
      end
      StScan: begin
        if (pick_found) begin
          slot_d  = pick_slot;
          len_d   = LVL_W'(BURST);
          valid_d = 1'b1;
          busy_d  = 1'b1;
          state_d = StIssue;
`ifdef MEM_BURST_SCHED_PARTIAL_FLUSH_EN
          if (flush_q) len_d = part_len_q[pick_slot];
          idle_cnt_d = '0;
          flush_d    = 1'b0;
`endif
        end else begin
          state_d = StIdle;
        end
      end
      StIssue: begin
        if (burst_ready) begin
          valid_d     = 1'b0;
          last_slot_d = burst_slot;
          count_d     = grant_count + 16'd1;
          if (burst_done) begin
            busy_d  = 1'b0;
            state_d = StIdle;
          end else begin
            state_d = StWaitDone;
          end
        end
      end
      StWaitDone: begin
        if (burst_done) begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      elig_q      <= '0;
      last_slot_q <= 4'd15;
      burst_valid <= 1'b0;
      burst_slot  <= '0;
      burst_len   <= '0;
      busy        <= 1'b0;
      grant_count <= '0;
    end else begin
      state_q     <= state_d;
      elig_q      <= elig_d;
      last_slot_q <= last_slot_d;
      burst_valid <= valid_d;
      burst_slot  <= slot_d;
      burst_len   <= len_d;
      busy        <= busy_d;
      grant_count <= count_d;
    end
  end

`ifdef MEM_BURST_SCHED_PARTIAL_FLUSH_EN
  // Idle-timeout flush state.
  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt_q <= '0;
      flush_q    <= 1'b0;
      part_len_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
      flush_q    <= flush_d;
      part_len_q <= part_len_d;
    end
  end
`endif

endmodule

// File: tb/tb_mem_burst_scheduler.sv
// Bench for mem_burst_scheduler: directed steps plus randomized levels,
// checked against a slot-level round-robin reference model.
module tb_mem_burst_scheduler;

  logic          clk = 1'b0;
  logic          reset;
  logic [15:0]   chan_enable;
  logic [87:0]   wr_bus, rd_bus;
  logic [255:0]  ram_bus;
  logic          burst_valid, burst_ready, burst_done, busy;
  logic [3:0]    burst_slot;
  logic [10:0]   burst_len;
  logic [15:0]   grant_count;

  int wr_lvl [8];
  int rd_sp  [8];
  int rl     [8];

  int ncmp = 0;
  int nfail = 0;
  int m_last;
  logic [15:0] m_cnt;
  int g_slot;

  always #5 clk = ~clk;

  always_comb begin
    wr_bus  = '0;
    rd_bus  = '0;
    ram_bus = '0;
    for (int i = 0; i < 8; i++) begin
      wr_bus[i*11 +: 11]  = 11'(wr_lvl[i]);
      rd_bus[i*11 +: 11]  = 11'(rd_sp[i]);
      ram_bus[i*32 +: 32] = 32'(rl[i]);
    end
  end

  mem_burst_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .chan_enable   (chan_enable),
    .wr_fifo_level (wr_bus),
    .rd_fifo_space (rd_bus),
    .ram_level     (ram_bus),
    .burst_valid   (burst_valid),
    .burst_slot    (burst_slot),
    .burst_len     (burst_len),
    .burst_ready   (burst_ready),
    .burst_done    (burst_done),
    .busy          (busy),
    .grant_count   (grant_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Slots that deserve a full 32-byte burst right now.
  function automatic logic [15:0] model_elig();
    logic [15:0] v = '0;
    for (int i = 0; i < 8; i++) begin
      v[i]   = chan_enable[i] && wr_lvl[i] >= 32;
      v[8+i] = chan_enable[8+i] && rd_sp[i] >= 32 && rl[i] >= 32;
    end
    return v;
  endfunction

  function automatic int model_pick(input logic [15:0] v, input int last);
    for (int k = 1; k <= 16; k++) begin
      if (v[(last + k) % 16]) return (last + k) % 16;
    end
    return -1;
  endfunction

  function automatic int rnd_lvl();
    case ($urandom % 4)
      0: return 0;
      1: return 31;
      2: return 32;
      default: return int'($urandom_range(0, 2047));
    endcase
  endfunction

  task automatic clear_inputs();
    chan_enable = 16'hFFFF;
    for (int i = 0; i < 8; i++) begin
      wr_lvl[i] = 0;
      rd_sp[i]  = 0;
      rl[i]     = 0;
    end
  endtask

  task automatic randomize_inputs();
    chan_enable = 16'($urandom | $urandom);
    for (int i = 0; i < 8; i++) begin
      wr_lvl[i] = rnd_lvl();
      rd_sp[i]  = rnd_lvl();
      rl[i]     = rnd_lvl();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    burst_ready = 1'b0;
    burst_done = 1'b0;
    tick();
    tick();
    chk("rst_valid", 32'(burst_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_count", 32'(grant_count), 0);
    chk("rst_slot", 32'(burst_slot), 0);
    chk("rst_len", 32'(burst_len), 0);
    reset = 1'b0;
    m_last = 15;
    m_cnt = '0;
  endtask

  // Wait (bounded) for a command and compare it with the model's choice.
  task automatic check_grant();
    logic [15:0] v;
    v = model_elig();
    g_slot = model_pick(v, m_last);
    for (int n = 0; n < 6; n++) begin
      if (burst_valid) break;
      tick();
    end
    chk("grant_valid", 32'(burst_valid), 1);
    chk("grant_slot", 32'(burst_slot), 32'(g_slot));
    chk("grant_len", 32'(burst_len), 32);
    chk("grant_busy", 32'(busy), 1);
  endtask

  // Stall, accept, then finish the burst; optionally pick new inputs mid-burst.
  task automatic accept_grant(input bit rerand, input bit sep_done);
    int h;
    bit dn;
    h = int'($urandom_range(0, 3));
    for (int j = 0; j < h; j++) begin
      if (rerand && j == 0) randomize_inputs();
      burst_done = 1'($urandom % 2);
      tick();
      chk("hold_valid", 32'(burst_valid), 1);
      chk("hold_slot", 32'(burst_slot), 32'(g_slot));
      chk("hold_len", 32'(burst_len), 32);
    end
    if (rerand && h == 0) randomize_inputs();
    dn = sep_done ? 1'b0 : 1'($urandom % 2);
    burst_ready = 1'b1;
    burst_done = dn;
    tick();
    burst_ready = 1'b0;
    burst_done = 1'b0;
    m_last = g_slot;
    m_cnt = m_cnt + 16'd1;
    chk("acc_valid", 32'(burst_valid), 0);
    chk("acc_count", 32'(grant_count), 32'(m_cnt));
    if (dn) begin
      chk("acc_busy_done", 32'(busy), 0);
    end else begin
      chk("wait_busy", 32'(busy), 1);
      repeat ($urandom_range(0, 2)) tick();
      burst_done = 1'b1;
      tick();
      burst_done = 1'b0;
      chk("done_busy", 32'(busy), 0);
    end
  endtask

  initial begin
    int order [6];
    order = '{0, 3, 9, 0, 3, 9};
    reset = 1'b1;
    burst_ready = 1'b0;
    burst_done = 1'b0;
    clear_inputs();
    wr_lvl[0] = 32;

    // First grant latency after reset release.
    do_reset();
    tick();
    chk("lat_early", 32'(burst_valid), 0);
    tick();
    chk("lat_valid", 32'(burst_valid), 1);
    check_grant();
    accept_grant(1'b0, 1'b1);

    // Three contenders rotate 0,3,9 with immediate ready/done.
    clear_inputs();
    do_reset();
    wr_lvl[0] = 32;
    wr_lvl[3] = 100;
    rd_sp[1] = 32;
    rl[1] = 500;
    for (int g = 0; g < 6; g++) begin
      check_grant();
      chk("rr_order", 32'(burst_slot), 32'(order[g]));
      burst_ready = 1'b1;
      burst_done = 1'b1;
      tick();
      burst_ready = 1'b0;
      burst_done = 1'b0;
      m_last = g_slot;
      m_cnt = m_cnt + 16'd1;
    end
    chk("rr_count6", 32'(grant_count), 6);

    // Ten stalled cycles with inputs churning must not disturb the command.
    check_grant();
    for (int j = 0; j < 10; j++) begin
      randomize_inputs();
      tick();
      chk("stall_valid", 32'(burst_valid), 1);
      chk("stall_slot", 32'(burst_slot), 32'(g_slot));
      chk("stall_len", 32'(burst_len), 32);
    end
    clear_inputs();
    accept_grant(1'b0, 1'b0);

    // Read slot 12 just short on RAM level, then exactly enough.
    clear_inputs();
    wr_lvl[2] = 31;
    rd_sp[4] = 40;
    rl[4] = 31;
    for (int j = 0; j < 6; j++) begin
      tick();
      chk("short_idle", 32'(burst_valid), 0);
    end
    rl[4] = 32;
    check_grant();
    chk("slot12", 32'(burst_slot), 12);
    accept_grant(1'b0, 1'b0);

    // Reset while waiting for done; a stray done afterwards changes nothing.
    clear_inputs();
    wr_lvl[6] = 64;
    check_grant();
    burst_ready = 1'b1;
    tick();
    burst_ready = 1'b0;
    chk("pre_rst_busy", 32'(busy), 1);
    clear_inputs();
    do_reset();
    burst_done = 1'b1;
    tick();
    burst_done = 1'b0;
    chk("stray_count", 32'(grant_count), 0);
    chk("stray_busy", 32'(busy), 0);
    wr_lvl[0] = 32;
    wr_lvl[5] = 32;
    rd_sp[6] = 33;
    rl[6] = 33;
    check_grant();
    chk("post_rst_slot0", 32'(burst_slot), 0);
    accept_grant(1'b0, 1'b0);

    // Randomized traffic.
    randomize_inputs();
    for (int it = 0; it < 60; it++) begin
      if (model_elig() == 16'h0) begin
        for (int j = 0; j < 5; j++) begin
          tick();
          chk("none_valid", 32'(burst_valid), 0);
        end
        randomize_inputs();
      end else begin
        check_grant();
        accept_grant(1'b1, 1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_burst_scheduler.md
Name: mem_burst_scheduler

Overview:
- Round-robin scheduler that shares the single cell-RAM port between 16 tracking-FIFO channels.
- Channels 0-7 are write channels (FIFO->RAM): EP2 ports 0-3 and ADC slots 0-3.
- Channels 8-15 are read channels (RAM->FIFO): DAC slots 0-3 and EP6 ports 0-3.
- Decides which channel gets the next fixed-size burst and hands a command to the memory arbitrator's burst engine; it does not move data.

Parameters:
- NUM_CH, 8, channels per direction; total slots = 2*NUM_CH.
- BURST, 32, bytes per full burst.
- LVL_W, 11, width of FIFO level/space inputs.
- CNT_W, 32, width of RAM-resident byte counts.
- FLUSH_TIMEOUT, 1024, idle cycles before a partial flush (optional feature only).

Ports:
- clk  in  1  system clock (100-150 MHz).
- reset  in  1  synchronous, active-high.
- chan_enable  in  2*NUM_CH  per-slot enable; bit k = slot k.
- wr_fifo_level  in  NUM_CH*LVL_W  bytes waiting in each write FIFO; channel i at [i*LVL_W +: LVL_W].
- rd_fifo_space  in  NUM_CH*LVL_W  free bytes in each read FIFO.
- ram_level  in  NUM_CH*CNT_W  bytes held in RAM for each read channel.
- burst_valid  out  1  command valid.
- burst_slot  out  4  granted slot 0..15.
- burst_len  out  LVL_W  bytes in this burst.
- burst_ready  in  1  engine accepts command.
- burst_done  in  1  engine finished current burst (1-cycle pulse).
- busy  out  1  high from grant until done.
- grant_count  out  16  total bursts issued; wraps.

Behaviour:
- Reset: one clock, synchronous, active-high.
  - All outputs go to 0.
  - Round-robin pointer last_slot = 15, so the first scan starts at slot 0.
  - FSM = IDLE.
- Eligibility (combinational):
  - Write slot i: chan_enable[i] && wr_fifo_level[i] >= BURST.
  - Read slot 8+i: chan_enable[8+i] && rd_fifo_space[i] >= BURST && ram_level[i] >= BURST.
- FSM states:
  - IDLE: register the 16-bit eligibility vector into elig_q; go to SCAN.
  - SCAN:
    - If elig_q == 0, return to IDLE.
    - Otherwise pick the first set bit searching last_slot+1, last_slot+2, ... mod 16.
    - Load burst_slot, set burst_len = BURST, set burst_valid = 1 and busy = 1; go to ISSUE.
  - ISSUE:
    - Hold burst_valid, burst_slot and burst_len stable until burst_ready = 1.
    - On accept: burst_valid = 0, last_slot = burst_slot, grant_count += 1.
    - If burst_done is also high in the accept cycle, go to IDLE; otherwise go to WAIT_DONE.
  - WAIT_DONE: on burst_done, busy = 0; go to IDLE.
- Latency: an eligible slot with idle FSM gets burst_valid asserted 2 cycles after eligibility is sampled (IDLE -> SCAN -> ISSUE).
- Back-to-back grants are at most one per 3 cycles, given ready and done arrive immediately.
- Boundary conditions:
  - burst_done in IDLE, SCAN or ISSUE before accept: ignored.
  - chan_enable dropping during ISSUE or WAIT_DONE: the burst is not cancelled; the slot is simply ineligible at the next scan.
  - Inputs changing during SCAN: no effect; only the elig_q snapshot is used.
  - A single eligible slot equal to last_slot is re-granted (wrap to itself).
  - Level exactly BURST: eligible. Level BURST-1: not eligible (base build).
  - grant_count wraps 0xFFFF -> 0x0000.
  - Reset mid-burst: command is dropped and outputs cleared; the engine must also be reset by the same signal.

Optional Feature:
- Macro: MEM_BURST_SCHED_PARTIAL_FLUSH_EN.
- Enabled:
  - A 16-bit idle counter increments each cycle the FSM is in IDLE/SCAN with elig_q == 0, and clears on any grant or on reset.
  - When the counter reaches FLUSH_TIMEOUT, the next SCAN uses the partial vector instead.
  - Partial vector: write slots with level > 0, read slots with min(space, ram_level) > 0.
  - burst_len = that amount (capped at BURST), round-robin from last_slot+1. The counter then clears.
- Disabled: only full bursts are issued; the counter logic is absent.

Test Plan:
- Reset, then wr_fifo_level[0] = 32 with all enables set -> burst_valid at cycle 2 after release, slot 0, len 32; ready pulse then done pulse -> grant_count = 1, busy = 0.
- Slots 0, 3 and 9 continuously eligible, ready and done immediate -> grants in order 0, 3, 9, 0, 3, 9; grant_count = 6 after 6 grants.
- Hold burst_ready = 0 for 10 cycles while changing levels -> burst_valid, burst_slot and burst_len stable all 10 cycles.
- Read slot 12: rd_fifo_space = 40, ram_level = 31 -> never granted; raise ram_level to 32 -> granted with slot 12.
- Assert reset in WAIT_DONE, then a stray burst_done -> outputs 0, no grant_count change; next grant starts search at slot 0.
- With the macro enabled and FLUSH_TIMEOUT = 16: wr_fifo_level[5] = 7 only -> after 16 idle cycles, grant slot 5, len 7.
